// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : aes_pkg
//  Description : Shared constants, load FSM state type and round-count helper
//                for the multi-context AES round-key store.
//  Revision    : 1.0 - initial release
// ============================================================================
package aes_pkg;

    // Width of one round key and of one schedule word on the write port
    localparam int AES_RK_W    = 128;
    localparam int AES_WORD_W  = 64;
    // Round index width (rounds 0..14 fit in 4 bits)
    localparam int AES_ROUND_W = 4;

    // Load FSM states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        ZERO = 2'd2
    } ld_state_t;

    // Number of AES rounds for a given key size
    function automatic int aes_nr(input int key_bits);
        return (key_bits == 256) ? 14 : 10;
    endfunction

endpackage
`default_nettype wire

// File: rtl/aes_keyram_bank.sv
`default_nettype none
// ============================================================================
//  Module      : aes_keyram_bank
//  Description : Simple dual-port RAM, synchronous write, one-cycle registered
//                read. No reset on the array or read register so the block
//                maps onto a block RAM.
//  Revision    : 1.0 - initial release
// ============================================================================
module aes_keyram_bank #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [0:(1<<ADDR_W)-1];
    logic [DATA_W-1:0] r_rdata;

    // Write port
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Registered read port; holds its value while i_re is low
    always_ff @(posedge clk) begin
        if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/aes_keyram_multi.sv
`default_nettype none
// ============================================================================
//  Module      : aes_keyram_multi
//  Description : Multi-context round-key store. KEY_SLOTS expanded AES-128 or
//                AES-256 key schedules are loaded 64 bits at a time and read
//                back as 128-bit round keys by (slot, round) with one cycle
//                of latency. Per-slot ready flags gate every read.
//  Options     : AES_KEYRAM_ZEROIZE_EN - adds zeroize/zero_slot/zero_busy and
//                a ZERO sweep that wipes one slot's schedule.
//  Revision    : 1.0 - initial release
// ============================================================================
module aes_keyram_multi
    import aes_pkg::*;
#(
    parameter int KEY_BITS  = 128,
    parameter int KEY_SLOTS = 4,
    parameter int SLOT_W    = (KEY_SLOTS > 1) ? $clog2(KEY_SLOTS) : 1
) (
    input  logic                   clk,
    input  logic                   kill,
    input  logic                   en_wr,
    input  logic [SLOT_W-1:0]      wr_slot,
    input  logic [AES_WORD_W-1:0]  key_round_wr,
    input  logic                   rd_en,
    input  logic [SLOT_W-1:0]      rd_slot,
    input  logic [AES_ROUND_W-1:0] rd_round,
    output logic [AES_RK_W-1:0]    key_round_rd,
    output logic                   rd_valid,
    output logic                   rd_err_irq_pulse,
    output logic [KEY_SLOTS-1:0]   key_ready,
`ifdef AES_KEYRAM_ZEROIZE_EN
    input  logic                   zeroize,
    input  logic [SLOT_W-1:0]      zero_slot,
    output logic                   zero_busy,
`endif
    output logic                   wr_collision_irq_pulse
);

    localparam int         NR          = aes_nr(KEY_BITS);
    localparam int         ADDR_W      = SLOT_W + AES_ROUND_W;
    localparam logic [3:0] c_NR        = 4'(NR);
    localparam logic [4:0] c_LAST_WORD = 5'(2 * (NR + 1) - 1);

    if (KEY_BITS != 128 && KEY_BITS != 256) begin : g_bad_key_bits
        $error("aes_keyram_multi: KEY_BITS must be 128 or 256");
    end
    if (KEY_SLOTS < 1 || KEY_SLOTS > 16 || (KEY_SLOTS & (KEY_SLOTS - 1)) != 0) begin : g_bad_key_slots
        $error("aes_keyram_multi: KEY_SLOTS must be a power of 2 in 1..16");
    end

    ld_state_t             r_state;
    ld_state_t             w_state_nxt;
    logic [SLOT_W-1:0]     r_ld_slot;
    logic [4:0]            r_cnt;
    logic [3:0]            r_zcnt;
    logic [KEY_SLOTS-1:0]  r_key_ready;
    logic                  r_rd_valid;
    logic                  r_rd_err;
    logic                  r_rd_zero;

    logic                  w_zero_req;
    logic [SLOT_W-1:0]     w_zero_slot;
    logic                  w_ld_start;
    logic                  w_ld_word;
    logic                  w_ld_last;
    logic                  w_z_start;
    logic                  w_z_last;
    logic                  w_rd_ok;
    logic                  w_we_hi;
    logic                  w_we_lo;
    logic [ADDR_W-1:0]     w_wr_addr;
    logic [AES_WORD_W-1:0] w_wr_data;
    logic [AES_WORD_W-1:0] w_rd_hi;
    logic [AES_WORD_W-1:0] w_rd_lo;

`ifdef AES_KEYRAM_ZEROIZE_EN
    logic r_wr_coll;
    assign w_zero_req = zeroize;
    assign w_zero_slot = zero_slot;
    assign zero_busy = (r_state == ZERO);
    assign wr_collision_irq_pulse = r_wr_coll;

    // Writes arriving while a sweep runs or starts are dropped and flagged
    always_ff @(posedge clk) begin
        if (kill) begin
            r_wr_coll <= 1'b0;
        end else begin
            r_wr_coll <= en_wr && ((r_state == ZERO) || w_z_start);
        end
    end
`else
    assign w_zero_req = 1'b0;
    assign w_zero_slot = '0;
    assign wr_collision_irq_pulse = 1'b0;
`endif

    // Load-path decode: a word 0 either opens a load from IDLE or aborts a
    // load in progress when it targets a different slot
    assign w_ld_start = en_wr && (((r_state == IDLE) && !w_zero_req) ||
                                  ((r_state == LOAD) && (wr_slot != r_ld_slot)));
    assign w_ld_word  = en_wr && (r_state == LOAD) && (wr_slot == r_ld_slot);
    assign w_ld_last  = w_ld_word && (r_cnt == c_LAST_WORD);
    assign w_z_start  = (r_state == IDLE) && w_zero_req;
    assign w_z_last   = (r_state == ZERO) && (r_zcnt == c_NR);

    // State register
    always_ff @(posedge clk) begin
        if (kill) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_z_start) begin
                    w_state_nxt = ZERO;
                end else if (w_ld_start) begin
                    w_state_nxt = LOAD;
                end
            end
            LOAD: begin
                if (w_ld_last) begin
                    w_state_nxt = IDLE;
                end
            end
            ZERO: begin
                if (w_z_last) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // RAM write controls: even words go to the hi bank, odd words to the lo
    // bank; the sweep clears both halves of one row per cycle
    always_comb begin
        w_we_hi   = 1'b0;
        w_we_lo   = 1'b0;
        w_wr_addr = '0;
        w_wr_data = key_round_wr;
        if (w_ld_start) begin
            w_we_hi   = 1'b1;
            w_wr_addr = {wr_slot, 4'd0};
        end else if (w_ld_word) begin
            w_we_hi   = ~r_cnt[0];
            w_we_lo   = r_cnt[0];
            w_wr_addr = {r_ld_slot, r_cnt[4:1]};
        end else if (r_state == ZERO) begin
            w_we_hi   = 1'b1;
            w_we_lo   = 1'b1;
            w_wr_addr = {r_ld_slot, r_zcnt};
            w_wr_data = '0;
        end
    end

    // Word counter and target slot of the current load or sweep
    always_ff @(posedge clk) begin
        if (kill) begin
            r_ld_slot <= '0;
            r_cnt     <= '0;
        end else if (w_ld_start) begin
            r_ld_slot <= wr_slot;
            r_cnt     <= 5'd1;
        end else if (w_ld_last) begin
            r_cnt     <= '0;
        end else if (w_ld_word) begin
            r_cnt     <= r_cnt + 5'd1;
        end else if (w_z_start) begin
            r_ld_slot <= w_zero_slot;
        end
    end

    // Sweep row counter
    always_ff @(posedge clk) begin
        if (kill) begin
            r_zcnt <= '0;
        end else if (r_state == ZERO) begin
            r_zcnt <= w_z_last ? 4'd0 : r_zcnt + 4'd1;
        end
    end

    // Per-slot ready flags: cleared when a load or sweep begins, set once the
    // final schedule word has been written
    always_ff @(posedge clk) begin
        if (kill) begin
            r_key_ready <= '0;
        end else begin
            if (w_ld_start) begin
                r_key_ready[wr_slot] <= 1'b0;
            end
            if (w_ld_last) begin
                r_key_ready[r_ld_slot] <= 1'b1;
            end
            if (w_z_start) begin
                r_key_ready[w_zero_slot] <= 1'b0;
            end
        end
    end

    assign w_rd_ok = rd_en && r_key_ready[rd_slot] && (rd_round <= c_NR);

    // Read status; r_rd_zero forces the output to zero after an error or
    // reset and keeps the last good key otherwise
    always_ff @(posedge clk) begin
        if (kill) begin
            r_rd_valid <= 1'b0;
            r_rd_err   <= 1'b0;
            r_rd_zero  <= 1'b1;
        end else begin
            r_rd_valid <= w_rd_ok;
            r_rd_err   <= rd_en && !w_rd_ok;
            if (rd_en) begin
                r_rd_zero <= !w_rd_ok;
            end
        end
    end

    aes_keyram_bank #(
        .ADDR_W (ADDR_W),
        .DATA_W (AES_WORD_W)
    ) u_bank_hi (
        .clk     (clk),
        .i_we    (w_we_hi && !kill),
        .i_waddr (w_wr_addr),
        .i_wdata (w_wr_data),
        .i_re    (w_rd_ok && !kill),
        .i_raddr ({rd_slot, rd_round}),
        .o_rdata (w_rd_hi)
    );

    aes_keyram_bank #(
        .ADDR_W (ADDR_W),
        .DATA_W (AES_WORD_W)
    ) u_bank_lo (
        .clk     (clk),
        .i_we    (w_we_lo && !kill),
        .i_waddr (w_wr_addr),
        .i_wdata (w_wr_data),
        .i_re    (w_rd_ok && !kill),
        .i_raddr ({rd_slot, rd_round}),
        .o_rdata (w_rd_lo)
    );

    assign key_round_rd     = r_rd_zero ? '0 : {w_rd_hi, w_rd_lo};
    assign rd_valid         = r_rd_valid;
    assign rd_err_irq_pulse = r_rd_err;
    assign key_ready        = r_key_ready;

endmodule
`default_nettype wire
